// File: rtl/tff_toggle_arbiter.sv
// rtl/tff_toggle_arbiter.sv - round-robin arbiter sequencing toggle masks onto a shared T-FF bank
// One requester owns the bank at a time; its latched mask drives t_out for len cycles.
module tff_toggle_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   mask,
   input  logic [NREQ*4-1:0]       len,
   input  logic                    clr,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic                    busy,
   output logic [WIDTH-1:0]        t_out,
   output logic [WIDTH-1:0]        q
);

   localparam int PW = $clog2(NREQ);
   localparam logic [NREQ-1:0] ONE = 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     owner;
   logic [PW-1:0]     win;
   logic [PW-1:0]     idx;
   logic [PW:0]       sum;
   logic              found;
   logic [WIDTH-1:0]  mask_w;
   logic [WIDTH-1:0]  mask_lat;
   logic [3:0]        len_w;
   logic [3:0]        cnt;
   logic [NREQ-1:0]   done_r;

   // Scan from ptr upward, wrapping, so the last winner has lowest priority next time.
   always_comb begin
      win   = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ))
            sum = sum - (PW+1)'(NREQ);
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      mask_w = '0;
      len_w  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            mask_w = mask[i*WIDTH +: WIDTH];
            len_w  = len[i*4 +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (found && len_w != 4'd0) state_nxt = RUN;
         RUN:  if (cnt == 4'd1)            state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr      <= '0;
         owner    <= '0;
         cnt      <= '0;
         mask_lat <= '0;
         done_r   <= '0;
      end else begin
         done_r <= '0;
         if (state == IDLE) begin
            if (found) begin
               mask_lat <= mask_w;
               cnt      <= len_w;
               owner    <= win;
               ptr      <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
               // A zero-length request completes at the grant edge without ever owning the bank.
               if (len_w == 4'd0)
                  done_r <= ONE << win;
            end
         end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1)
               done_r <= ONE << owner;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q <= '0;
      else if (clr)
         q <= '0;
      else
         q <= q ^ t_out;
   end

   always_comb begin
      busy  = (state == RUN);
      t_out = busy ? mask_lat : '0;
      gnt   = busy ? (ONE << owner) : '0;
      done  = done_r;
   end

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// tb/tb_tff_toggle_arbiter.sv - directed vector bench for tff_toggle_arbiter
// Each table row: inputs for a cycle plus the outputs expected during that cycle.
module tb_tff_toggle_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] mask;
   logic [15:0] len;
   logic        clr;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic [7:0]  t_out;
   logic [7:0]  q;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] mask;
      logic [15:0] len;
      logic        clr;
      logic [3:0]  gnt;
      logic [3:0]  done;
      logic        busy;
      logic [7:0]  t;
      logic [7:0]  q;
   } vec_t;

   vec_t vecs[$];

   tff_toggle_arbiter #(.WIDTH(8), .NREQ(4)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .mask  (mask),
      .len   (len),
      .clr   (clr),
      .gnt   (gnt),
      .done  (done),
      .busy  (busy),
      .t_out (t_out),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] eg, input logic [3:0] ed,
                            input logic eb, input logic [7:0] et, input logic [7:0] eq);
      check({tag, " gnt"},   {4'b0, gnt},  {4'b0, eg});
      check({tag, " done"},  {4'b0, done}, {4'b0, ed});
      check({tag, " busy"},  {7'b0, busy}, {7'b0, eb});
      check({tag, " t_out"}, t_out, et);
      check({tag, " q"},     q, eq);
   endtask

   task automatic add(input logic [3:0] r, input logic [31:0] m, input logic [15:0] l,
                      input logic c, input logic [3:0] eg, input logic [3:0] ed,
                      input logic eb, input logic [7:0] et, input logic [7:0] eq);
      vec_t v;
      v.req = r; v.mask = m; v.len = l; v.clr = c;
      v.gnt = eg; v.done = ed; v.busy = eb; v.t = et; v.q = eq;
      vecs.push_back(v);
   endtask

   initial begin
      // Round robin: all four requesting, len=1 each, mask=1<<i
      add(4'hF, 32'h08040201, 16'h1111, 0, 4'h0, 4'h0, 0, 8'h00, 8'h00);
      add(4'hF, 32'h08040201, 16'h1111, 0, 4'h1, 4'h0, 1, 8'h01, 8'h00);
      add(4'hF, 32'h08040201, 16'h1111, 0, 4'h0, 4'h1, 0, 8'h00, 8'h01);
      add(4'hF, 32'h08040201, 16'h1111, 0, 4'h2, 4'h0, 1, 8'h02, 8'h01);
      add(4'hF, 32'h08040201, 16'h1111, 0, 4'h0, 4'h2, 0, 8'h00, 8'h03);
      add(4'hF, 32'h08040201, 16'h1111, 0, 4'h4, 4'h0, 1, 8'h04, 8'h03);
      add(4'hF, 32'h08040201, 16'h1111, 0, 4'h0, 4'h4, 0, 8'h00, 8'h07);
      add(4'hF, 32'h08040201, 16'h1111, 0, 4'h8, 4'h0, 1, 8'h08, 8'h07);
      add(4'hF, 32'h08040201, 16'h1111, 0, 4'h0, 4'h8, 0, 8'h00, 8'h0F);
      add(4'h0, 32'h08040201, 16'h1111, 0, 4'h1, 4'h0, 1, 8'h01, 8'h0F);
      add(4'h0, 32'h08040201, 16'h1111, 0, 4'h0, 4'h1, 0, 8'h00, 8'h0E);
      add(4'h0, 32'h08040201, 16'h1111, 1, 4'h0, 4'h0, 0, 8'h00, 8'h0E);
      // Single request: req0, mask 05, len 3
      add(4'h1, 32'h00000005, 16'h0003, 0, 4'h0, 4'h0, 0, 8'h00, 8'h00);
      add(4'h0, 32'h00000005, 16'h0003, 0, 4'h1, 4'h0, 1, 8'h05, 8'h00);
      add(4'h0, 32'h00000005, 16'h0003, 0, 4'h1, 4'h0, 1, 8'h05, 8'h05);
      add(4'h0, 32'h00000005, 16'h0003, 0, 4'h1, 4'h0, 1, 8'h05, 8'h00);
      add(4'h0, 32'h00000005, 16'h0003, 0, 4'h0, 4'h1, 0, 8'h00, 8'h05);
      add(4'h0, 32'h00000005, 16'h0003, 0, 4'h0, 4'h0, 0, 8'h00, 8'h05);
      // Zero length on req2, then ptr=3 must favour req3 over req0
      add(4'h4, 32'h00FF0000, 16'h0000, 0, 4'h0, 4'h0, 0, 8'h00, 8'h05);
      add(4'h0, 32'h00FF0000, 16'h0000, 0, 4'h0, 4'h4, 0, 8'h00, 8'h05);
      add(4'h9, 32'h80000000, 16'h1000, 0, 4'h0, 4'h0, 0, 8'h00, 8'h05);
      add(4'h0, 32'h80000000, 16'h1000, 0, 4'h8, 4'h0, 1, 8'h80, 8'h05);
      add(4'h0, 32'h80000000, 16'h1000, 0, 4'h0, 4'h8, 0, 8'h00, 8'h85);
      // Clear mid-run: req1, mask 03, len 4; mask/len changes during RUN ignored
      add(4'h2, 32'h00000300, 16'h0040, 1, 4'h0, 4'h0, 0, 8'h00, 8'h85);
      add(4'h0, 32'h0000FF00, 16'h00F0, 0, 4'h2, 4'h0, 1, 8'h03, 8'h00);
      add(4'h0, 32'h0000FF00, 16'h00F0, 1, 4'h2, 4'h0, 1, 8'h03, 8'h03);
      add(4'h0, 32'h0000FF00, 16'h00F0, 0, 4'h2, 4'h0, 1, 8'h03, 8'h00);
      add(4'h0, 32'h0000FF00, 16'h00F0, 0, 4'h2, 4'h0, 1, 8'h03, 8'h03);
      add(4'h0, 32'h0000FF00, 16'h00F0, 0, 4'h0, 4'h2, 0, 8'h00, 8'h00);
      add(4'h0, 32'h0000FF00, 16'h00F0, 0, 4'h0, 4'h0, 0, 8'h00, 8'h00);

      // Reset held with all requests pending
      reset = 1'b0;
      req   = 4'hF;
      mask  = 32'h08040201;
      len   = 16'h1111;
      clr   = 1'b0;
      #1 check_all("rst0", 4'h0, 4'h0, 0, 8'h00, 8'h00);
      repeat (2) begin
         @(posedge clk); #1;
         check_all("rst_hold", 4'h0, 4'h0, 0, 8'h00, 8'h00);
      end
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         req  = vecs[i].req;
         mask = vecs[i].mask;
         len  = vecs[i].len;
         clr  = vecs[i].clr;
         #1;
         check_all($sformatf("row%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy,
                   vecs[i].t, vecs[i].q);
         @(posedge clk); #1;
      end

      // Reset mid-run: req0 len 10, mask 11; ptr is 2 so scan wraps to req0
      req = 4'h1; mask = 32'h00000011; len = 16'h000A; clr = 1'b0;
      @(posedge clk); #1;
      req = 4'h0;
      check_all("mr_grant", 4'h1, 4'h0, 1, 8'h11, 8'h00);
      repeat (3) @(posedge clk);
      #1 check_all("mr_3tog", 4'h1, 4'h0, 1, 8'h11, 8'h11);
      #2 reset = 1'b0;
      #1 check_all("mr_async", 4'h0, 4'h0, 0, 8'h00, 8'h00);
      @(posedge clk); #1;
      check_all("mr_held", 4'h0, 4'h0, 0, 8'h00, 8'h00);
      req = 4'h8; mask = 32'h40000000; len = 16'h2000;
      reset = 1'b1;
      @(posedge clk); #1;
      req = 4'h0;
      check_all("mr_req3", 4'h8, 4'h0, 1, 8'h40, 8'h00);
      @(posedge clk); #1;
      check_all("mr_tog1", 4'h8, 4'h0, 1, 8'h40, 8'h40);
      @(posedge clk); #1;
      check_all("mr_done", 4'h0, 4'h8, 0, 8'h00, 8'h00);
      @(posedge clk); #1;
      check_all("mr_idle", 4'h0, 4'h0, 0, 8'h00, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
